// File: rtl/wb_uart_tx_if.sv
// Wishbone slave bus bundle for the UART transmitter.
// Signal names follow the management SoC wbs_* port.
interface wb_uart_tx_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter with a small TX FIFO.
// Drives one user IO pad (io_out / io_oeb) directly.
module wb_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd867
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  wb_uart_tx_if.slave wbs,
  output logic        tx_o,
  output logic        tx_oeb_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic        hit;
  logic        req;
  logic [1:0]  reg_sel;
  logic        wr_data;
  logic        wr_stat;
  logic        wr_div;
  logic        wr_ctrl;
  logic [31:0] rdata;

  logic [15:0] div_q;
  logic [2:0]  ctrl_q;
  logic        ovf;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [3:0]    lvl4;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [15:0] div_lat, dlat_n;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  shreg, sh_n;
  logic        tx_n;
  logic        tick;
  logic        busy;
  logic        start_ok;
  logic        unused_ok;

  assign hit = wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign req = wbs.wbs_stb_i & wbs.wbs_cyc_i
             & hit & ~wbs.wbs_ack_o;
  assign reg_sel = wbs.wbs_adr_i[3:2];

  assign wr_data = req & wbs.wbs_we_i
                 & (reg_sel == 2'd0) & wbs.wbs_sel_i[0];
  assign wr_stat = req & wbs.wbs_we_i
                 & (reg_sel == 2'd1) & wbs.wbs_sel_i[0]
                 & wbs.wbs_dat_i[3];
  assign wr_div  = req & wbs.wbs_we_i & (reg_sel == 2'd2);
  assign wr_ctrl = req & wbs.wbs_we_i
                 & (reg_sel == 2'd3) & wbs.wbs_sel_i[0];

  assign unused_ok = ^{wbs.wbs_sel_i[3:2],
                       wbs.wbs_adr_i[1:0],
                       wbs.wbs_dat_i[31:16]};

  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign push  = wr_data & ~full;
  assign head  = mem[rd_ptr];
  assign lvl4  = 4'(level);

  assign busy     = state != IDLE;
  assign tick     = timer == '0;
  assign start_ok = ctrl_q[0] & ~empty;

  // Register read mux; STATUS is a snapshot of pre-edge state.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: rdata = '0;
      2'd1: rdata = {20'd0, lvl4, 4'd0,
                     ovf, busy, empty, full};
      2'd2: rdata = {16'd0, div_q};
      2'd3: rdata = {29'd0, ctrl_q};
    endcase
  end

  // Single-cycle ack and read data, both registered on the request edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      wbs.wbs_ack_o <= req;
      wbs.wbs_dat_o <= (req & ~wbs.wbs_we_i) ? rdata : '0;
    end
  end

  // Control registers and sticky overflow flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      div_q  <= DIV_RESET;
      ctrl_q <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_div && wbs.wbs_sel_i[0])
        div_q[7:0] <= wbs.wbs_dat_i[7:0];
      if (wr_div && wbs.wbs_sel_i[1])
        div_q[15:8] <= wbs.wbs_dat_i[15:8];
      if (wr_ctrl)
        ctrl_q <= wbs.wbs_dat_i[2:0];
      if (wr_data && full)
        ovf <= 1'b1;
      else if (wr_stat)
        ovf <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since level gates reads.
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr] <= wbs.wbs_dat_i[7:0];
  end

  // FIFO pointers and level; push is dropped on pre-pop full.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  // TX FSM next state, bit timing and line value.
  always_comb begin
    state_n = state;
    timer_n = timer;
    dlat_n  = div_lat;
    idx_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx_o;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          sh_n    = head;
          dlat_n  = div_q;
          timer_n = div_q;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (!tick) begin
          timer_n = timer - 16'd1;
        end else begin
          timer_n = div_lat;
          idx_n   = 3'd0;
          tx_n    = shreg[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          timer_n = timer - 16'd1;
        end else if (bit_idx == 3'd7) begin
          timer_n = div_lat;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          timer_n = div_lat;
          sh_n    = {1'b0, shreg[7:1]};
          tx_n    = shreg[1];
          idx_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          timer_n = timer - 16'd1;
        end else if (start_ok) begin
          pop     = 1'b1;
          sh_n    = head;
          dlat_n  = div_q;
          timer_n = div_q;
          tx_n    = 1'b0;
          state_n = START;
        end else begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // TX FSM state and datapath registers; line idles high in reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      timer   <= '0;
      div_lat <= DIV_RESET;
      bit_idx <= '0;
      shreg   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      div_lat <= dlat_n;
      bit_idx <= idx_n;
      shreg   <= sh_n;
      tx_o    <= tx_n;
    end
  end

  // Registered pad enable and interrupt.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_oeb_o <= 1'b1;
      irq_o    <= 1'b0;
    end else begin
      tx_oeb_o <= ~ctrl_q[1];
      irq_o    <= ctrl_q[2] & empty & ~busy;
    end
  end

endmodule
